// File: rtl/csa_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module  : csa_accum_pkg
// Purpose : Shared types and default widths for the carry-save accumulator.
//           - state_t : 2-bit controller state (IDLE, ACCUM, RESOLVE, DONE)
//           - CSA_DW / CSA_AW / CSA_CW : default operand, result and count
//             widths
// Revision: 1.0  initial release
// ============================================================================
package csa_accum_pkg;

  localparam int CSA_DW = 16;
  localparam int CSA_AW = CSA_DW + 8;
  localparam int CSA_CW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/csa_accum_row.sv
`default_nettype none
// ============================================================================
// Module  : csa_row
// Purpose : Bitwise 3:2 compressor across an AW-bit row. Combinational only.
// Ports   : i_a, i_b, i_c  AW-bit addends
//           o_s            bitwise sum      (a ^ b ^ c)
//           o_c            bitwise carry    (majority of a, b, c), unshifted
// Revision: 1.0  initial release
// ============================================================================
module csa_row #(
  parameter int AW = 24
) (
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  input  logic [AW-1:0] i_c,
  output logic [AW-1:0] o_s,
  output logic [AW-1:0] o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_b & i_c) | (i_c & i_a);

endmodule
`default_nettype wire

// File: rtl/csa_accum.sv
`default_nettype none
// ============================================================================
// Module  : csa_accum
// Purpose : Streaming multi-operand accumulator. Operands arrive on a
//           valid/ready port and are folded into a redundant sum/carry pair
//           (no carry propagation per beat). After the last operand a single
//           carry-propagate add resolves the total, which is offered on a
//           valid/ready result port.
// Ports   : clk        rising-edge clock
//           nreset     asynchronous active-low reset
//           in_valid / in_ready / in_data[DW] / in_last   operand stream
//           out_valid / out_ready                         result handshake
//           out_sum[AW]    packet total, modulo 2^AW
//           out_count[CW]  operands in packet, saturating at 2^CW-1
// Config  : CSA_ACCUM_SIGNED_EN - when defined, operands are sign-extended
//           from bit DW-1 (two's-complement total); otherwise zero-extended.
// Note    : AW must be >= DW.
// Revision: 1.0  initial release
// ============================================================================
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int DW = CSA_DW,
  parameter int AW = DW + 8,
  parameter int CW = CSA_CW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count
);

  state_t        r_state;
  state_t        w_next;

  logic [AW-1:0] r_s;
  logic [AW-1:0] r_c;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_out_sum;
  logic [CW-1:0] r_out_count;

  logic [AW-1:0] w_x;
  logic [AW-1:0] w_c2;
  logic [AW-1:0] w_row_s;
  logic [AW-1:0] w_row_c;
  logic [CW-1:0] w_count_inc;
  logic          w_accept;

  // Operand extension to accumulator width.
`ifdef CSA_ACCUM_SIGNED_EN
  assign w_x = AW'($signed(in_data));
`else
  assign w_x = AW'(in_data);
`endif

  // The carry word carries weight 2; the bit shifted out of the top is
  // beyond 2^AW and is dropped, which is exactly the modulo wrap.
  assign w_c2 = r_c << 1;

  assign w_accept    = in_valid & in_ready;
  assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);

  csa_row #(
    .AW (AW)
  ) u_row (
    .i_a (r_s),
    .i_b (w_c2),
    .i_c (w_x),
    .o_s (w_row_s),
    .o_c (w_row_c)
  );

  // --------------------------------------------------------------------------
  // Controller: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_next = RESOLVE;
        end
      end
      RESOLVE: begin
        w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: redundant accumulator, operand count and resolved result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_s         <= '0;
      r_c         <= '0;
      r_count     <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // First beat loads the sum word directly; no compression needed.
          if (w_accept) begin
            r_s     <= w_x;
            r_c     <= '0;
            r_count <= CW'(1);
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_s     <= w_row_s;
            r_c     <= w_row_c;
            r_count <= w_count_inc;
          end
        end
        RESOLVE: begin
          r_out_sum   <= r_s + w_c2;
          r_out_count <= r_count;
        end
        DONE: begin
          if (out_ready) begin
            r_s     <= '0;
            r_c     <= '0;
            r_count <= '0;
          end
        end
        default: begin
          r_s     <= '0;
          r_c     <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_csa_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_csa_accum
// Purpose : Self-checking bench for csa_accum (DW=16, AW=24, CW=8).
//           A packet-level reference model (plain integer sums) is compared
//           against the DUT on every falling edge; directed packets also pin
//           hand-computed literal results.
// Config  : CSA_ACCUM_SIGNED_EN selects signed operand extension in the
//           model and the signed literal expectation.
// Revision: 1.0  initial release
// ============================================================================
module tb_csa_accum;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  csa_accum #(
    .DW (DW),
    .AW (AW),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: packet phase 0 = taking operands, 1 = resolving,
  // 2 = result offered. Totals are plain integer sums, wrapped to AW bits.
  // --------------------------------------------------------------------------
  function automatic logic [AW-1:0] ext(input logic [DW-1:0] d);
`ifdef CSA_ACCUM_SIGNED_EN
    return {{(AW-DW){d[DW-1]}}, d};
`else
    return {{(AW-DW){1'b0}}, d};
`endif
  endfunction

  int            m_ph     = 0;
  logic [AW-1:0] m_acc    = '0;
  int            m_cnt    = 0;
  logic [AW-1:0] m_res    = '0;
  int            m_rescnt = 0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_ph     <= 0;
      m_acc    <= '0;
      m_cnt    <= 0;
      m_res    <= '0;
      m_rescnt <= 0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          m_acc <= m_acc + ext(in_data);
          m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
          if (in_last) m_ph <= 1;
        end
        1: begin
          m_res    <= m_acc;
          m_rescnt <= m_cnt;
          m_ph     <= 2;
        end
        default: if (out_ready) begin
          m_acc <= '0;
          m_cnt <= 0;
          m_ph  <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("model_in_ready",  32'(in_ready),  32'(m_ph == 0));
    chk("model_out_valid", 32'(out_valid), 32'(m_ph == 2));
    chk("model_out_sum",   32'(out_sum),   32'(m_res));
    chk("model_out_count", 32'(out_count), 32'(m_rescnt));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; all start and end on a falling edge.
  // --------------------------------------------------------------------------
  task automatic beat(input logic [DW-1:0] d, input logic l);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("beat_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the cycle right after the last beat was accepted.
  task automatic finish_pkt(input string name, input logic [31:0] esum, input logic [31:0] ecnt);
    chk({name, "_resolve_in_ready"},  32'(in_ready),  32'd0);
    chk({name, "_resolve_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_out_sum"},   32'(out_sum),   esum);
    chk({name, "_out_count"}, 32'(out_count), ecnt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Back-to-back four-operand packet.
    beat(16'd3, 1'b0);
    beat(16'd5, 1'b0);
    beat(16'd7, 1'b0);
    beat(16'd9, 1'b1);
    finish_pkt("p3579", 32'd24, 32'd4);

    // Single-beat packet with out_ready raised early (no effect before valid).
    out_ready = 1'b1;
    beat(16'h1234, 1'b1);
    chk("single_resolve_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_sum",   32'(out_sum),   32'h001234);
    chk("single_out_count", 32'(out_count), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("single_released", 32'(out_valid), 32'd0);

    // 256 x 0xFFFF: count saturates at 255.
    for (int i = 0; i < 256; i++) beat(16'hFFFF, (i == 255));
`ifdef CSA_ACCUM_SIGNED_EN
    finish_pkt("p256", 32'hFFFF00, 32'd255);
`else
    finish_pkt("p256", 32'hFFFF00, 32'd255);
`endif

    // 257 x 0xFFFF: unsigned total 0x100FEFF wraps to 0x00FEFF;
    // signed total is -257 = 0xFFFEFF.
    for (int i = 0; i < 257; i++) beat(16'hFFFF, (i == 256));
`ifdef CSA_ACCUM_SIGNED_EN
    finish_pkt("p257", 32'hFFFEFF, 32'd255);
`else
    finish_pkt("p257", 32'h00FEFF, 32'd255);
`endif

    // Mixed-sign packet, then 5 cycles of backpressure with ignored input.
    beat(16'hFFFF, 1'b0);
    beat(16'hFFFE, 1'b0);
    beat(16'h0001, 1'b1);
    chk("bp_resolve_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5555;
`ifdef CSA_ACCUM_SIGNED_EN
      chk("bp_out_sum", 32'(out_sum), 32'hFFFFFE);
`else
      chk("bp_out_sum", 32'(out_sum), 32'h01FFFE);
`endif
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_count", 32'(out_count), 32'd3);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-packet: discard, return to reset values, then {1,1}.
    beat(16'd10, 1'b0);
    beat(16'd20, 1'b0);
    #2 nreset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sum",   32'(out_sum),   32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    beat(16'd1, 1'b0);
    beat(16'd1, 1'b1);
    finish_pkt("p11", 32'd2, 32'd2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
